// File: rtl/axi_lite_imp_dma_csr_if.sv
// AXI-Lite bus bundle used as the register access port of the image-DMA CSR block.
interface AXI_LITE #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic                        aw_valid, aw_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_valid, w_ready;
  logic [1:0]                  b_resp;
  logic                        b_valid, b_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic                        ar_valid, ar_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_valid, r_ready;

  modport Slave (
    input  aw_addr, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input  ar_addr, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
  modport Master (
    output aw_addr, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input  b_resp, b_valid, output b_ready,
    output ar_addr, ar_valid, input ar_ready,
    input  r_data, r_resp, r_valid, output r_ready
  );
endinterface

// File: rtl/axi_lite_imp_dma_csr.sv
// AXI-Lite CSR block for NUM_CH image-DMA channels: config, start pulses, W1C status, done counter, irq.
// Define IMP_DMA_CSR_CFG_LOCK_EN to reject config writes (0x00-0x0C) on a busy channel with SLVERR.
module axi_lite_imp_dma_csr #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h0010_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  AXI_LITE.Slave               slv,
  output logic [NUM_CH*32-1:0] ch_baddr_o,
  output logic [NUM_CH*32-1:0] ch_pitch_o,
  output logic [NUM_CH*16-1:0] ch_hsize_o,
  output logic [NUM_CH*16-1:0] ch_vsize_o,
  output logic [NUM_CH*8-1:0]  ch_minx_o,
  output logic [NUM_CH*8-1:0]  ch_miny_o,
  output logic [NUM_CH-1:0]    ch_start_o,
  input  logic [NUM_CH-1:0]    ch_busy_i,
  input  logic [NUM_CH-1:0]    ch_done_i,
  input  logic [NUM_CH-1:0]    ch_err_i,
  output logic                 irq_o
);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(32 * NUM_CH);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic [1:0]  bresp_q, rresp_q, w_resp;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, w_hs, r_hs, w_hit, r_hit, busy_w;
  logic [AXI_ADDR_WIDTH-1:0] w_off, r_off;
  logic [2:0]  w_ch, w_reg, r_ch, r_reg;

  logic [NUM_CH-1:0][31:0] baddr_a, pitch_a, size_a;
  logic [NUM_CH-1:0][15:0] minxy_a, cnt_a;
  logic [NUM_CH-1:0]       irq_en_a, done_a, err_a, irq_src;

  // Subtracting the base makes below-base addresses wrap to large offsets, so one compare decodes both ends.
  assign w_off = slv.aw_addr - BASE_ADDR;
  assign r_off = slv.ar_addr - BASE_ADDR;
  assign w_hit = w_off < SPAN;
  assign r_hit = r_off < SPAN;
  assign w_ch  = w_off[7:5];
  assign w_reg = w_off[4:2];
  assign r_ch  = r_off[7:5];
  assign r_reg = r_off[4:2];
  assign w_hs  = (w_state_q == W_IDLE) & slv.aw_valid & slv.w_valid;
  assign r_hs  = (r_state_q == R_IDLE) & slv.ar_valid;

  always_comb begin
    busy_w = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (w_ch == 3'(c)) busy_w = ch_busy_i[c];
    w_resp = OKAY;
    if (!w_hit)
      w_resp = DECERR;
    else if (w_reg == 3'd4 && slv.w_strb[0] && slv.w_data[0] && busy_w)
      w_resp = SLVERR;
`ifdef IMP_DMA_CSR_CFG_LOCK_EN
    else if (!w_reg[2] && busy_w)
      w_resp = SLVERR;
`endif
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [31:0] baddr_q, pitch_q, size_q;
    logic [15:0] minxy_q, cnt_q;
    logic        irq_en_q, done_q, err_q, start_q;
    logic        sel, lock, cfg_we, ctrl_we, stat_we, start_rej;

    assign sel = w_hs & w_hit & (w_ch == 3'(c));
`ifdef IMP_DMA_CSR_CFG_LOCK_EN
    assign lock = ch_busy_i[c];
`else
    assign lock = 1'b0;
`endif
    assign cfg_we    = sel & ~w_reg[2] & ~lock;
    assign ctrl_we   = sel & (w_reg == 3'd4) & slv.w_strb[0];
    assign stat_we   = sel & (w_reg == 3'd5) & slv.w_strb[0];
    assign start_rej = ctrl_we & slv.w_data[0] & ch_busy_i[c];

    always_ff @(posedge clk) begin
      if (rst) begin
        baddr_q <= '0; pitch_q <= '0; size_q <= '0; minxy_q <= '0; cnt_q <= '0;
        irq_en_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; start_q <= 1'b0;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (cfg_we && slv.w_strb[b]) begin
            if (w_reg == 3'd0) baddr_q[8*b +: 8] <= slv.w_data[8*b +: 8];
            if (w_reg == 3'd1) pitch_q[8*b +: 8] <= slv.w_data[8*b +: 8];
            if (w_reg == 3'd2) size_q[8*b +: 8]  <= slv.w_data[8*b +: 8];
          end
        end
        for (int b = 0; b < 2; b++)
          if (cfg_we && w_reg == 3'd3 && slv.w_strb[b]) minxy_q[8*b +: 8] <= slv.w_data[8*b +: 8];
        if (ctrl_we) irq_en_q <= slv.w_data[1];
        start_q <= ctrl_we & slv.w_data[0] & ~ch_busy_i[c];
        // Hardware set events take priority over a simultaneous software clear.
        done_q <= ch_done_i[c] | (done_q & ~(stat_we & slv.w_data[1]));
        err_q  <= ch_err_i[c] | start_rej | (err_q & ~(stat_we & slv.w_data[2]));
        if (ch_done_i[c]) cnt_q <= cnt_q + 16'd1;
      end
    end

    assign baddr_a[c]  = baddr_q;
    assign pitch_a[c]  = pitch_q;
    assign size_a[c]   = size_q;
    assign minxy_a[c]  = minxy_q;
    assign cnt_a[c]    = cnt_q;
    assign irq_en_a[c] = irq_en_q;
    assign done_a[c]   = done_q;
    assign err_a[c]    = err_q;
    assign irq_src[c]  = irq_en_q & (done_q | err_q);
    assign ch_start_o[c]          = start_q;
    assign ch_baddr_o[32*c +: 32] = baddr_q;
    assign ch_pitch_o[32*c +: 32] = pitch_q;
    assign ch_hsize_o[16*c +: 16] = size_q[15:0];
    assign ch_vsize_o[16*c +: 16] = size_q[31:16];
    assign ch_minx_o[8*c +: 8]    = minxy_q[7:0];
    assign ch_miny_o[8*c +: 8]    = minxy_q[15:8];
  end

  always_comb begin
    rdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_hit && r_ch == 3'(c)) begin
        case (r_reg)
          3'd0:    rdata_d = baddr_a[c];
          3'd1:    rdata_d = pitch_a[c];
          3'd2:    rdata_d = size_a[c];
          3'd3:    rdata_d = {16'h0, minxy_a[c]};
          3'd4:    rdata_d = {30'h0, irq_en_a[c], 1'b0};
          3'd5:    rdata_d = {29'h0, err_a[c], done_a[c], ch_busy_i[c]};
          3'd6:    rdata_d = {16'h0, cnt_a[c]};
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      bresp_q   <= OKAY;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      if (w_hs) bresp_q <= w_resp;
      if (r_hs) begin
        rdata_q <= rdata_d;
        rresp_q <= r_hit ? OKAY : DECERR;
      end
      irq_q <= |irq_src;
    end
  end

  always_comb begin
    w_state_d    = w_state_q;
    slv.aw_ready = 1'b0;
    slv.w_ready  = 1'b0;
    slv.b_valid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        slv.aw_ready = slv.aw_valid & slv.w_valid;
        slv.w_ready  = slv.aw_valid & slv.w_valid;
        if (slv.aw_valid && slv.w_valid) w_state_d = W_RESP;
      end
      W_RESP: begin
        slv.b_valid = 1'b1;
        if (slv.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d    = r_state_q;
    slv.ar_ready = 1'b0;
    slv.r_valid  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        slv.ar_ready = 1'b1;
        if (slv.ar_valid) r_state_d = R_RESP;
      end
      R_RESP: begin
        slv.r_valid = 1'b1;
        if (slv.r_ready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign slv.b_resp = bresp_q;
  assign slv.r_resp = rresp_q;
  assign slv.r_data = rdata_q;
  assign irq_o      = irq_q;
endmodule

// File: tb/tb_axi_lite_imp_dma_csr.sv
// Scoreboard bench for axi_lite_imp_dma_csr: directed AXI-Lite traffic, expected responses queued at issue.
module tb_axi_lite_imp_dma_csr;
  localparam logic [31:0] B = 32'h0010_0000;
  localparam logic [1:0] OK = 2'b00, SE = 2'b10, DE = 2'b11;

  logic clk = 1'b0, rst = 1'b1;
  logic [63:0] ch_baddr_o, ch_pitch_o;
  logic [31:0] ch_hsize_o, ch_vsize_o;
  logic [15:0] ch_minx_o, ch_miny_o;
  logic [1:0]  ch_start_o, ch_busy_i, ch_done_i, ch_err_i;
  logic        irq_o;

  AXI_LITE #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) slv ();

  axi_lite_imp_dma_csr #(.NUM_CH(2), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .BASE_ADDR(B)) dut (
    .clk(clk), .rst(rst), .slv(slv),
    .ch_baddr_o(ch_baddr_o), .ch_pitch_o(ch_pitch_o), .ch_hsize_o(ch_hsize_o), .ch_vsize_o(ch_vsize_o),
    .ch_minx_o(ch_minx_o), .ch_miny_o(ch_miny_o), .ch_start_o(ch_start_o),
    .ch_busy_i(ch_busy_i), .ch_done_i(ch_done_i), .ch_err_i(ch_err_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int start_cnt0 = 0, start_cnt1 = 0;
  logic [1:0]  exp_b[$];
  string       nm_b[$];
  logic [31:0] exp_rd[$];
  logic [1:0]  exp_rr[$];
  string       nm_r[$];

  always @(posedge clk) begin
    if (ch_start_o[0]) start_cnt0++;
    if (ch_start_o[1]) start_cnt1++;
  end

  // Monitor: pops the oldest expectation whenever a response handshake is presented.
  always @(negedge clk) begin
    if (slv.b_valid && slv.b_ready) begin
      n_cmp++;
      if (exp_b.size() == 0) begin
        n_fail++; $display("FAIL b_unexpected: got bresp=%0b with nothing queued", slv.b_resp);
      end else begin
        logic [1:0] e; string n;
        e = exp_b.pop_front(); n = nm_b.pop_front();
        if (slv.b_resp !== e) begin
          n_fail++; $display("FAIL %s: bresp got %0b want %0b", n, slv.b_resp, e);
        end
      end
    end
    if (slv.r_valid && slv.r_ready) begin
      n_cmp++;
      if (exp_rd.size() == 0) begin
        n_fail++; $display("FAIL r_unexpected: got rdata=%h with nothing queued", slv.r_data);
      end else begin
        logic [31:0] ed; logic [1:0] er; string n;
        ed = exp_rd.pop_front(); er = exp_rr.pop_front(); n = nm_r.pop_front();
        if (slv.r_data !== ed || slv.r_resp !== er) begin
          n_fail++;
          $display("FAIL %s: got rdata=%h rresp=%0b want rdata=%h rresp=%0b", n, slv.r_data, slv.r_resp, ed, er);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++; $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic axw(input string n, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] er);
    int k;
    exp_b.push_back(er); nm_b.push_back(n);
    slv.aw_addr = a; slv.w_data = d; slv.w_strb = s;
    slv.aw_valid = 1'b1; slv.w_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!(slv.aw_ready && slv.w_ready) && k < 20) begin @(negedge clk); k++; end
    if (!(slv.aw_ready && slv.w_ready)) begin
      n_cmp++; n_fail++; $display("FAIL %s: aw/w handshake timeout", n);
      void'(exp_b.pop_front()); void'(nm_b.pop_front());
      slv.aw_valid = 1'b0; slv.w_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    slv.aw_valid = 1'b0; slv.w_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!slv.b_valid && k < 20) begin @(negedge clk); k++; end
    if (!slv.b_valid) begin
      n_cmp++; n_fail++; $display("FAIL %s: bvalid timeout", n);
      void'(exp_b.pop_front()); void'(nm_b.pop_front());
    end
    tick(1);
  endtask

  task automatic axr(input string n, input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    int k;
    exp_rd.push_back(ed); exp_rr.push_back(er); nm_r.push_back(n);
    slv.ar_addr = a; slv.ar_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!slv.ar_ready && k < 20) begin @(negedge clk); k++; end
    if (!slv.ar_ready) begin
      n_cmp++; n_fail++; $display("FAIL %s: ar handshake timeout", n);
      void'(exp_rd.pop_front()); void'(exp_rr.pop_front()); void'(nm_r.pop_front());
      slv.ar_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    slv.ar_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!slv.r_valid && k < 20) begin @(negedge clk); k++; end
    if (!slv.r_valid) begin
      n_cmp++; n_fail++; $display("FAIL %s: rvalid timeout", n);
      void'(exp_rd.pop_front()); void'(exp_rr.pop_front()); void'(nm_r.pop_front());
    end
    tick(1);
  endtask

  initial begin
    int s0;
    logic [31:0] pitch_exp;
    logic [1:0]  pitch_resp;
    slv.aw_addr = '0; slv.aw_valid = 1'b0; slv.w_data = '0; slv.w_strb = '0; slv.w_valid = 1'b0;
    slv.b_ready = 1'b1; slv.ar_addr = '0; slv.ar_valid = 1'b0; slv.r_ready = 1'b1;
    ch_busy_i = '0; ch_done_i = '0; ch_err_i = '0;
    tick(3);
    rst = 1'b0;
    tick(1);

    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_start", {30'h0, ch_start_o}, 32'h0);
    chk("rst_baddr_lo", ch_baddr_o[31:0], 32'h0);
    chk("rst_bvalid", {30'h0, slv.b_valid, slv.r_valid}, 32'h0);
    for (int i = 0; i < 8; i++) axr("rst_read_ch0", B + 32'(4 * i), 32'h0, OK);

    axw("baddr1_full", B + 32'h20, 32'hFFFF_FFFF, 4'hF, OK);
    axw("baddr1_strb", B + 32'h20, 32'h8000_1000, 4'b0011, OK);
    chk("baddr1_out", ch_baddr_o[63:32], 32'hFFFF_1000);
    chk("baddr0_out", ch_baddr_o[31:0], 32'h0);
    axr("baddr1_rd", B + 32'h20, 32'hFFFF_1000, OK);

    axw("size0_wr", B + 32'h08, 32'h0120_0280, 4'hF, OK);
    chk("hsize0", {16'h0, ch_hsize_o[15:0]}, 32'h0280);
    chk("vsize0", {16'h0, ch_vsize_o[15:0]}, 32'h0120);
    axw("minxy0_wr", B + 32'h0C, 32'hFFFF_3412, 4'hF, OK);
    chk("minx0_miny0", {16'h0, ch_miny_o[7:0], ch_minx_o[7:0]}, 32'h3412);
    axr("minxy0_rd", B + 32'h0C, 32'h0000_3412, OK);

    s0 = start_cnt0;
    axw("start0_idle", B + 32'h10, 32'h3, 4'h1, OK);
    tick(3);
    chk("start0_pulses", 32'(start_cnt0 - s0), 32'd1);
    chk("start1_none", 32'(start_cnt1), 32'd0);
    axr("ctrl0_rd", B + 32'h10, 32'h2, OK);
    ch_done_i[0] = 1'b1; tick(1); ch_done_i[0] = 1'b0;
    tick(3);
    axr("status0_done", B + 32'h14, 32'h2, OK);
    axr("cnt0_one", B + 32'h18, 32'h1, OK);
    chk("irq_done0", {31'h0, irq_o}, 32'h1);
    axw("status0_w1c", B + 32'h14, 32'h2, 4'h1, OK);
    tick(2);
    chk("irq_cleared", {31'h0, irq_o}, 32'h0);
    axr("status0_clr", B + 32'h14, 32'h0, OK);

    ch_busy_i[0] = 1'b1; tick(1);
    s0 = start_cnt0;
    axw("start0_busy", B + 32'h10, 32'h3, 4'h1, SE);
    tick(3);
    chk("start0_busy_nopulse", 32'(start_cnt0 - s0), 32'd0);
    axr("status0_busy_err", B + 32'h14, 32'h5, OK);
    chk("irq_err0", {31'h0, irq_o}, 32'h1);
`ifdef IMP_DMA_CSR_CFG_LOCK_EN
    pitch_exp = 32'h0; pitch_resp = SE;
`else
    pitch_exp = 32'h1234; pitch_resp = OK;
`endif
    axw("pitch0_busy", B + 32'h04, 32'h1234, 4'hF, pitch_resp);
    axr("pitch0_rd", B + 32'h04, pitch_exp, OK);
    ch_busy_i[0] = 1'b0; tick(1);
    axw("status0_w1c_err", B + 32'h14, 32'h4, 4'h1, OK);
    axr("status0_err_clr", B + 32'h14, 32'h0, OK);

    axr("decerr_top_rd", B + 32'h40, 32'h0, DE);
    axr("decerr_below_rd", B - 32'h4, 32'h0, DE);
    axw("decerr_wr", B + 32'h40, 32'hFFFF_FFFF, 4'hF, DE);
    axr("after_decerr_b0", B, 32'h0, OK);
    axr("after_decerr_b1", B + 32'h20, 32'hFFFF_1000, OK);
    axr("lowbits_ignored", B + 32'h23, 32'hFFFF_1000, OK);
    axr("reserved_rd", B + 32'h1C, 32'h0, OK);

    ch_done_i[1] = 1'b1; tick(1); ch_done_i[1] = 1'b0;
    ch_done_i[1] = 1'b1;
    fork
      axw("status1_w1c_race", B + 32'h34, 32'h2, 4'h1, OK);
      begin tick(1); ch_done_i[1] = 1'b0; end
    join
    axr("status1_set_wins", B + 32'h34, 32'h2, OK);
    axr("cnt1_two", B + 32'h38, 32'h2, OK);
    axw("status1_w1c", B + 32'h34, 32'h2, 4'h1, OK);
    axr("status1_clr", B + 32'h34, 32'h0, OK);
    ch_done_i[1] = 1'b1; tick(65534); ch_done_i[1] = 1'b0;
    tick(1);
    axr("cnt1_wrap", B + 32'h38, 32'h0, OK);

    // Reset lands on a write handshake edge and while a read response is pending.
    s0 = start_cnt0;
    slv.r_ready = 1'b0;
    slv.ar_addr = B; slv.ar_valid = 1'b1;
    tick(1);
    slv.ar_valid = 1'b0;
    slv.aw_addr = B + 32'h10; slv.w_data = 32'h1; slv.w_strb = 4'h1;
    slv.aw_valid = 1'b1; slv.w_valid = 1'b1; rst = 1'b1;
    tick(1);
    slv.aw_valid = 1'b0; slv.w_valid = 1'b0; rst = 1'b0; slv.r_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valids", {30'h0, slv.b_valid, slv.r_valid}, 32'h0);
    tick(3);
    chk("mid_rst_nopulse", 32'(start_cnt0 - s0), 32'd0);
    chk("mid_rst_baddr1", ch_baddr_o[63:32], 32'h0);
    axr("mid_rst_ctrl0", B + 32'h10, 32'h0, OK);
    chk("queues_drained", 32'(exp_b.size() + exp_rd.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
